// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servo_pkg
// Description : Shared constants and types for the five-channel servo PWM
//               bank: channel count, field widths, default timing values and
//               the 7-bit servo position type.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

   localparam int NUM_SERVOS = 5;
   localparam int POS_W      = 7;
   localparam int TICK_W     = 16;

   // Default timing, 100 MHz processor clock
   localparam int DEF_STEP_CYCLES = 1000;  // 10 us per position tick
   localparam int DEF_FRAME_TICKS = 2000;  // 20 ms frame
   localparam int DEF_BASE_TICKS  = 100;   // 1.0 ms pulse at position 0
   localparam int DEF_MAX_POS     = 100;   // 2.0 ms pulse at the clamp
   localparam int DEF_NEUTRAL_POS = 50;    // 1.5 ms reset position
   localparam int DEF_SLEW_STEP   = 4;     // positions per frame, slew build

   typedef logic [POS_W-1:0] servo_pos_t;

endpackage : servo_pkg
`default_nettype wire

// File: rtl/servo_pwm_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_bank_if
// Description : Register-file / pin side bundle of the servo PWM bank.
//   servo0..servo4 : target positions (master -> bank)
//   enable         : global output enable (master -> bank)
//   pwm_out[4:0]   : servo pulses, bit i for servo<i> (bank -> master)
//   frame_start    : one-clock strobe per frame boundary (bank -> master)
//   Modports: master = register file / test side, slave = the PWM bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface servo_pwm_bank_if;
   import servo_pkg::*;

   servo_pos_t            servo0;
   servo_pos_t            servo1;
   servo_pos_t            servo2;
   servo_pos_t            servo3;
   servo_pos_t            servo4;
   logic                  enable;
   logic [NUM_SERVOS-1:0] pwm_out;
   logic                  frame_start;

   modport master (
      output servo0, servo1, servo2, servo3, servo4, enable,
      input  pwm_out, frame_start
   );

   modport slave (
      input  servo0, servo1, servo2, servo3, servo4, enable,
      output pwm_out, frame_start
   );

endinterface : servo_pwm_bank_if
`default_nettype wire

// File: rtl/servo_channel.sv
`default_nettype none
// ============================================================================
// Module      : servo_channel
// Description : One servo output: clamps the target position, optionally
//               slews toward it, holds the per-frame shadow position and
//               generates the registered pulse by comparing the shared frame
//               counter with the pulse width.
//   clock, reset : system clock, asynchronous active-high reset
//   fc_i         : shared frame tick counter
//   boundary_i   : high for the single clock on which a frame ends
//   armed_i      : output permitted for the current frame
//   enable_i     : live global enable
//   servo_i      : target position from the register file
//   pwm_o        : servo pulse
//   Build option : SERVO_SLEW_EN limits the shadow change per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_channel
   import servo_pkg::*;
#(
   parameter int BASE_TICKS  = DEF_BASE_TICKS,
   parameter int MAX_POS     = DEF_MAX_POS,
   parameter int NEUTRAL_POS = DEF_NEUTRAL_POS,
   parameter int SLEW_STEP   = DEF_SLEW_STEP
)(
   input  logic              clock,
   input  logic              reset,
   input  logic [TICK_W-1:0] fc_i,
   input  logic              boundary_i,
   input  logic              armed_i,
   input  logic              enable_i,
   input  servo_pos_t        servo_i,
   output logic              pwm_o
);

   localparam servo_pos_t        MAX_POS_C  = servo_pos_t'(MAX_POS);
   localparam servo_pos_t        NEUTRAL_C  = servo_pos_t'(NEUTRAL_POS);
   localparam logic [TICK_W-1:0] BASE_C     = TICK_W'(BASE_TICKS);

   servo_pos_t        target;
   servo_pos_t        eff_q, eff_d;
   logic [TICK_W-1:0] width;
   logic              pwm_q, pwm_d;

   always_comb begin
      target = (servo_i > MAX_POS_C) ? MAX_POS_C : servo_i;
   end

`ifdef SERVO_SLEW_EN
   // Distance is computed one bit wider so the comparison against the step
   // never wraps, and the step is only added when it cannot pass the target.
   localparam logic [POS_W:0] SLEW_C = (POS_W+1)'(SLEW_STEP);
   localparam servo_pos_t     STEP_C = servo_pos_t'(SLEW_STEP);
   logic [POS_W:0] dist;

   always_comb begin
      eff_d = eff_q;
      dist  = '0;
      if (boundary_i) begin
         if (target > eff_q) begin
            dist  = {1'b0, target} - {1'b0, eff_q};
            eff_d = (dist > SLEW_C) ? (eff_q + STEP_C) : target;
         end else if (target < eff_q) begin
            dist  = {1'b0, eff_q} - {1'b0, target};
            eff_d = (dist > SLEW_C) ? (eff_q - STEP_C) : target;
         end
      end
   end
`else
   always_comb begin
      eff_d = boundary_i ? target : eff_q;
   end
`endif

   always_comb begin
      width = BASE_C + TICK_W'(eff_q);
      pwm_d = armed_i && enable_i && (fc_i < width);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         eff_q <= NEUTRAL_C;
         pwm_q <= 1'b0;
      end else begin
         eff_q <= eff_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule : servo_channel
`default_nettype wire

// File: rtl/servo_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_bank
// Description : Five-channel hobby-servo PWM generator. A shared prescaler and
//               frame counter form the timebase; each channel latches its
//               position once per frame so register writes never produce
//               runt or stretched pulses.
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : servo_pwm_bank_if.slave (servo0..4, enable in; pwm_out,
//           frame_start out)
//   Build option : SERVO_SLEW_EN enables per-frame position slew limiting.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_bank
   import servo_pkg::*;
#(
   parameter int STEP_CYCLES = DEF_STEP_CYCLES,
   parameter int FRAME_TICKS = DEF_FRAME_TICKS,
   parameter int BASE_TICKS  = DEF_BASE_TICKS,
   parameter int MAX_POS     = DEF_MAX_POS,
   parameter int NEUTRAL_POS = DEF_NEUTRAL_POS,
   parameter int SLEW_STEP   = DEF_SLEW_STEP
)(
   input  logic              clock,
   input  logic              reset,
   servo_pwm_bank_if.slave   bus
);

   // The longest pulse must end before the frame does, otherwise the output
   // would never return low between frames.
   if (!(FRAME_TICKS > BASE_TICKS + MAX_POS)) begin : g_bad_frame
      $error("servo_pwm_bank: FRAME_TICKS must exceed BASE_TICKS + MAX_POS");
   end
   if (SLEW_STEP < 1) begin : g_bad_slew
      $error("servo_pwm_bank: SLEW_STEP must be at least 1");
   end

   localparam logic [TICK_W-1:0] PC_LAST = TICK_W'(STEP_CYCLES - 1);
   localparam logic [TICK_W-1:0] FC_LAST = TICK_W'(FRAME_TICKS - 1);
   localparam logic [TICK_W-1:0] ONE     = TICK_W'(1);

   logic [TICK_W-1:0]     pc_q, pc_d;
   logic [TICK_W-1:0]     fc_q, fc_d;
   logic                  armed_q, armed_d;
   logic                  fs_q;
   logic                  tick;
   logic                  boundary;
   servo_pos_t            servo_arr [NUM_SERVOS];
   logic [NUM_SERVOS-1:0] pwm;

   always_comb begin
      tick     = (pc_q == PC_LAST);
      boundary = tick && (fc_q == FC_LAST);
      pc_d     = tick ? '0 : (pc_q + ONE);
      fc_d     = fc_q;
      if (tick) begin
         fc_d = boundary ? '0 : (fc_q + ONE);
      end
      // Dropping enable disarms immediately; re-arming waits for a boundary
      // so a mid-frame enable never emits a partial pulse.
      armed_d  = boundary ? bus.enable : (armed_q & bus.enable);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q    <= '0;
         fc_q    <= '0;
         armed_q <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         fc_q    <= fc_d;
         armed_q <= armed_d;
         fs_q    <= boundary;
      end
   end

   assign servo_arr[0] = bus.servo0;
   assign servo_arr[1] = bus.servo1;
   assign servo_arr[2] = bus.servo2;
   assign servo_arr[3] = bus.servo3;
   assign servo_arr[4] = bus.servo4;

   for (genvar g = 0; g < NUM_SERVOS; g++) begin : g_chan
      servo_channel #(
         .BASE_TICKS  (BASE_TICKS),
         .MAX_POS     (MAX_POS),
         .NEUTRAL_POS (NEUTRAL_POS),
         .SLEW_STEP   (SLEW_STEP)
      ) u_chan (
         .clock       (clock),
         .reset       (reset),
         .fc_i        (fc_q),
         .boundary_i  (boundary),
         .armed_i     (armed_q),
         .enable_i    (bus.enable),
         .servo_i     (servo_arr[g]),
         .pwm_o       (pwm[g])
      );
   end

   assign bus.pwm_out     = pwm;
   assign bus.frame_start = fs_q;

endmodule : servo_pwm_bank
`default_nettype wire
